decoder38_pulse: RTL and testbench
==================================

Name: decoder38_pulse

Overview:
- Registered 3-to-8 one-hot decoder with a valid/ready handshake. It is the receive-side counterpart of the 8-to-3 priority-free encoder (code + valid flag).
- Each accepted code drives exactly one output line high for a programmable number of cycles, then enforces a programmable idle gap before it accepts the next code.
- Accepted beats flagged invalid (V=0) produce no output pulse and are counted.
- Sits between encoder-side logic and LED, strobe or select lines that need a stretched, glitch-free one-hot pulse.

Parameters:
- HOLD_CYCLES, 4: cycles the one-hot output stays asserted per accepted code. Legal range 1..255; 0 behaves as 1.
- GAP_CYCLES, 1: cycles of forced not-ready after each hold. Legal range 0..255.
- CNT_W, 8: width of the hold/gap counter and of errCount.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inValid  in  1  upstream presents a beat.
- inReady  out  1  block can accept a beat this cycle.
- code  in  [0:2]  code[0] is the MSB; value k selects output line k.
- V  in  1  code-valid flag from the encoder side. 0 means no line is active.
- Y  out  [0:7]  registered one-hot output; Y[k] high for code k.
- active  out  1  high while Y is nonzero (HOLD state).
- done  out  1  one-cycle pulse in the first cycle after a hold ends.
- errCount  out  CNT_W  saturating count of accepted beats with V=0.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-hold):
  - state=IDLE; Y=0, active=0, done=0, errCount=0, counter=0.
  - inReady=1 once in IDLE.
  - Deassert is sampled at the next clk edge.
- States: IDLE, HOLD, GAP. inReady = (state==IDLE); it is combinational from the state register only.
- Accept = inValid && inReady at a rising edge. The input is not sampled otherwise; code and V are don't-care when not accepted.
- IDLE, accept with V=1:
  - Next cycle Y = one-hot(code), active=1, state=HOLD, counter=HOLD_CYCLES-1.
  - Latency is 1 cycle from the accepting edge to Y valid.
- IDLE, accept with V=0:
  - Y stays 0 and state stays IDLE.
  - errCount increments and saturates at 2^CNT_W-1 without wrapping. done is not pulsed.
- HOLD:
  - Y holds its value and is never modified by input activity.
  - When counter==0 at an edge:
    - Y<=0, active<=0, done<=1 for exactly one cycle.
    - If GAP_CYCLES==0, go to IDLE. Otherwise go to GAP with counter=GAP_CYCLES-1.
  - Otherwise the counter decrements.
  - Y is therefore high for exactly HOLD_CYCLES cycles.
- GAP:
  - Y=0, inReady=0.
  - When counter==0, go to IDLE; otherwise decrement.
  - Exactly GAP_CYCLES cycles of inReady=0 after the hold.
- Back-to-back with GAP_CYCLES=0:
  - inReady=1 in the cycle done=1, and an accept at the following edge is legal.
  - Minimum Y-low time between pulses is 1 cycle. Y never changes directly from one nonzero value to another.
- Y is at most one-hot at all times: no two bits are set and there are no glitches, since Y is driven from a register.
- Round trip: feeding Y into the 8-to-3 encoder returns the same code with V=1 during HOLD, and V=0 otherwise.
- All outputs are registered except inReady.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high → Y=8'b0, active=0, done=0, errCount=0, inReady=1.
- Single decode (HOLD=4, GAP=1): accept code=3'b101, V=1 → Y[5]=1 only, from the cycle after accept for exactly 4 cycles. Then done=1 for 1 cycle, inReady=0 for 1 cycle, then inReady=1.
- Exhaustive codes: accept codes 0..7 sequentially, each with V=1 → Y[k] is the only bit set each time. Encoder of Y returns k with V=1.
- Invalid beats: accept 3 beats with V=0 → Y stays 0, errCount=3, no done. With CNT_W=2, 5 beats → errCount saturates at 3.
- Back-to-back (HOLD=1, GAP=0): inValid held high with codes 2 then 6 → Y=bit2 for 1 cycle, 0 for 1 cycle, bit6 for 1 cycle. inValid ignored while inReady=0.
- Reset mid-hold: assert rst_n=0 asynchronously in the 2nd hold cycle of code 7 → Y=0 and active=0 immediately without waiting for clk, no done pulse, IDLE with inReady=1 after release.

Source files
------------

// File: rtl/decoder38_pulse.sv
// Registered 3-to-8 one-hot decoder with valid/ready handshake.
// Each accepted valid code produces a stretched one-hot pulse followed by a forced idle gap.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for a beat; Y is zero
// ST_HOLD | one line of Y asserted; down-counter times the pulse width
// ST_GAP  | Y zero, not ready; down-counter times the idle gap
module decoder38_pulse #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inValid,
   output logic             inReady,
   input  logic [0:2]       code,
   input  logic             V,
   output logic [0:7]       Y,
   output logic             active,
   output logic             done,
   output logic [CNT_W-1:0] errCount
);

   // A programmed hold of 0 is treated as a single-cycle hold.
   localparam int               HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES < 1) ? 0 : GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] ERR_MAX   = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [0:7]       y_q, y_d;
   logic             active_q, active_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             accept;

   assign inReady = (state_q == ST_IDLE);
   assign accept  = inValid && inReady;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      y_d      = y_q;
      active_d = active_q;
      done_d   = 1'b0;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (V) begin
                  y_d       = '0;
                  y_d[code] = 1'b1;
                  active_d  = 1'b1;
                  cnt_d     = HOLD_LOAD;
                  state_d   = ST_HOLD;
               end else if (err_q != ERR_MAX) begin
                  err_d = err_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               y_d      = '0;
               active_d = 1'b0;
               done_d   = 1'b1;
               if (GAP_CYCLES < 1) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_GAP;
                  cnt_d   = GAP_LOAD;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            y_d      = '0;
            active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         y_q      <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         y_q      <= y_d;
         active_q <= active_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign Y        = y_q;
   assign active   = active_q;
   assign done     = done_q;
   assign errCount = err_q;

endmodule

// File: tb/tb_decoder38_pulse.sv
// Scoreboard bench for decoder38_pulse: default build, back-to-back build (HOLD=1, GAP=0)
// and a narrow error counter build (CNT_W=2).
module tb_decoder38_pulse;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // main instance: HOLD=4, GAP=1, CNT_W=8
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [0:2] code_i = '0;
   logic       v_i = 1'b0;
   logic [0:7] y;
   logic       active, done;
   logic [7:0] err_cnt;

   // back-to-back instance: HOLD=1, GAP=0
   logic       in_valid_b = 1'b0;
   logic       in_ready_b;
   logic [0:2] code_b = '0;
   logic       v_b = 1'b1;
   logic [0:7] y_b;
   logic       active_b, done_b;
   logic [7:0] err_b;

   // saturation instance: CNT_W=2
   logic       in_valid_s = 1'b0;
   logic       in_ready_s;
   logic [0:2] code_s = '0;
   logic       v_s = 1'b0;
   logic [0:7] y_s;
   logic       active_s, done_s;
   logic [1:0] err_s;

   decoder38_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(in_ready), .code(code_i),
      .V(v_i), .Y(y), .active(active), .done(done), .errCount(err_cnt));

   decoder38_pulse #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) u_b2b (
      .clk(clk), .rst_n(rst_n), .inValid(in_valid_b), .inReady(in_ready_b), .code(code_b),
      .V(v_b), .Y(y_b), .active(active_b), .done(done_b), .errCount(err_b));

   decoder38_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .inValid(in_valid_s), .inReady(in_ready_s), .code(code_s),
      .V(v_s), .Y(y_s), .active(active_s), .done(done_s), .errCount(err_s));

   logic [2:0] sb_q[$];
   logic [2:0] b_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [0:7] onehot(input logic [2:0] c);
      logic [0:7] r;
      r    = '0;
      r[c] = 1'b1;
      return r;
   endfunction

   // reference 8-to-3 encoder: {V, code}
   function automatic logic [3:0] enc8(input logic [0:7] yy);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (yy[i]) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

   // main-instance output monitor: pops expected code at every pulse start
   logic [0:7] prev_y = '0;
   int         run_len = 0;
   logic [2:0] exp_code;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_y  = '0;
         run_len = 0;
      end else begin
         if (y != '0) begin
            chk("onehot", $countones(y), 1);
            chk("active_hi", active, 1'b1);
            if (prev_y == '0) begin
               if (sb_q.size() == 0) begin
                  chk("sb_unexpected", y, 0);
               end else begin
                  exp_code = sb_q.pop_front();
                  chk("sb_y", y, onehot(exp_code));
                  chk("enc_rt", enc8(y), {1'b1, exp_code});
               end
               run_len = 1;
            end else begin
               chk("y_stable", y, prev_y);
               run_len++;
            end
         end else if (prev_y != '0) begin
            chk("hold_len", run_len, 4);
            chk("done_at_end", done, 1'b1);
            chk("active_lo", active, 1'b0);
            chk("enc_idle", enc8(y), 4'd0);
         end
         if (done) chk("done_pos", prev_y != '0, 1'b1);
         prev_y = y;
      end
   end

   task automatic send(input logic [2:0] c, input logic v);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("ready_timeout", in_ready, 1'b1);
         return;
      end
      in_valid = 1'b1;
      code_i   = c;
      v_i      = v;
      if (v) sb_q.push_back(c);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      code_i   = 3'($urandom);
      v_i      = 1'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset then idle
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_y", y, 0);
      chk("rst_active", active, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err_cnt, 0);
      chk("rst_ready", in_ready, 1'b1);

      // single decode of code 5 with explicit timing
      send(3'd5, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("single_y", y, onehot(3'd5));
         chk("single_ready", in_ready, 1'b0);
      end
      @(negedge clk);
      chk("single_y_off", y, 0);
      chk("single_done", done, 1'b1);
      chk("single_gap_ready", in_ready, 1'b0);
      @(negedge clk);
      chk("single_done_off", done, 1'b0);
      chk("single_ready_back", in_ready, 1'b1);

      // every code, with one-cycle latency check
      for (int k = 0; k < 8; k++) begin
         send(3'(k), 1'b1);
         @(negedge clk);
         chk("lat_y", y, onehot(3'(k)));
      end

      // invalid beats
      for (int k = 0; k < 3; k++) begin
         send(3'(k + 1), 1'b0);
         @(negedge clk);
         chk("inv_done", done, 1'b0);
         chk("inv_y", y, 0);
      end
      chk("inv_err", err_cnt, 3);

      // back-to-back, inValid held high across not-ready cycle
      @(negedge clk);
      in_valid_b = 1'b1;
      code_b     = 3'd2;
      b_q.push_back(3'd2);
      @(posedge clk);
      #1;
      code_b = 3'd6;
      b_q.push_back(3'd6);
      @(negedge clk);
      chk("b2b_y_first", y_b, onehot(b_q.pop_front()));
      chk("b2b_not_ready", in_ready_b, 1'b0);
      @(negedge clk);
      chk("b2b_gap_y", y_b, 0);
      chk("b2b_gap_done", done_b, 1'b1);
      chk("b2b_gap_ready", in_ready_b, 1'b1);
      @(negedge clk);
      in_valid_b = 1'b0;
      chk("b2b_y_second", y_b, onehot(b_q.pop_front()));
      @(negedge clk);
      chk("b2b_end_y", y_b, 0);
      chk("b2b_end_done", done_b, 1'b1);
      chk("b2b_q_empty", b_q.size(), 0);

      // error counter saturation on the narrow build
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid_s = 1'b1;
         code_s     = 3'($urandom);
         @(posedge clk);
         #1;
         in_valid_s = 1'b0;
         @(negedge clk);
         chk("sat_err", err_s, (i < 3) ? i + 1 : 3);
         chk("sat_y", y_s, 0);
      end

      // asynchronous reset in the second hold cycle of code 7
      send(3'd7, 1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_y", y, 0);
      chk("mid_rst_active", active, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_ready", in_ready, 1'b1);
         chk("post_rst_done", done, 1'b0);
         chk("post_rst_y", y, 0);
      end
      chk("post_rst_err", err_cnt, 0);

      repeat (4) @(negedge clk);
      chk("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
